pio_irq_debounce: RTL
=====================

Name: pio_irq_debounce

Overview:
- Parametrised multi-channel Avalon-MM input PIO with interrupt, for touch/button interrupt lines on the SOPC system bus.
- Generalises the single-bit edge-capture PIO in four ways: WIDTH channels, configurable synchroniser depth, a per-channel programmable debounce filter, and per-channel runtime selection of rising and/or falling edge capture.
- Edge-capture bits are write-1-to-clear per bit.
- irq goes to the Nios II interrupt controller.

Parameters:
- WIDTH, 4: number of input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, >=2.
- CNT_W, 16: width of the debounce counter and the DEBOUNCE register, 1..32.
- RISE_RESET, {WIDTH{1'b0}}: reset value of the RISE_EN register.
- FALL_RESET, {WIDTH{1'b1}}: reset value of the FALL_EN register (default is falling edge, for active-low touch INT).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH or CNT_W are ignored.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt.

Behaviour:
- Register map. Reads zero-extend to 32 bits.
  - 0 DATA (RO): debounced stable value.
  - 1 RAW (RO): synchroniser output.
  - 2 IRQ_MASK (RW): reset 0.
  - 3 EDGE_CAP (RO, W1C): reset 0.
  - 4 RISE_EN (RW): reset RISE_RESET.
  - 5 FALL_EN (RW): reset FALL_RESET.
  - 6 DEBOUNCE (RW): reset 0.
  - 7: reads 0, writes ignored.
- Write: occurs when chipselect && !write_n, at the clock edge.
- Read:
  - readdata <= mux(address) on every edge, regardless of chipselect; read latency is 1 clock.
  - readdata resets to 0.
- Synchroniser:
  - Per-channel SYNC_STAGES-deep flop chain, reset 0.
  - sync[i] is the last stage.
- Debounce, per channel i: counter cnt[i] (CNT_W bits, reset 0) and stable[i] (reset 0).
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] >= DEBOUNCE: stable[i] <= sync[i], cnt[i] <= 0 (commit).
  - Else: cnt[i] <= cnt[i] + 1.
- Debounce consequences:
  - A level change commits on the (SYNC_STAGES + 1 + DEBOUNCE)-th rising edge after in_port changes. With DEBOUNCE=0 this is SYNC_STAGES+1 edges.
  - Pulses shorter than DEBOUNCE+1 cycles at the sync output are rejected.
  - The comparison is >=, so lowering DEBOUNCE mid-count commits on the next edge. The counter never wraps.
- Edge capture, per channel i, on the commit edge:
  - rise_evt = commit & sync[i] & RISE_EN[i].
  - fall_evt = commit & ~sync[i] & FALL_EN[i].
  - Either event sets EDGE_CAP[i].
- EDGE_CAP clearing and priority:
  - A write to address 3 clears each bit where writedata[i]=1; other bits are unchanged.
  - A set event and a clear on the same edge for the same bit: set wins.
  - Disabling RISE_EN or FALL_EN does not clear already-captured bits.
- irq:
  - irq = |(EDGE_CAP & IRQ_MASK), combinational from registers.
  - Asserts the edge after capture if masked-in; unmasking a pending bit asserts irq immediately.
  - irq resets low.
- Reset mid-operation: asynchronous clear of all flops. Counters, stable, sync and EDGE_CAP go to 0, and no spurious edge follows. If an input is held at 1 through reset, a rising commit occurs after SYNC_STAGES+1+DEBOUNCE edges and is captured only if RISE_EN=1.

Test Plan:
1. Reset defaults: WIDTH=4. Assert reset_n=0 mid-cycle, then read addresses 0..7 → readdata = 0, 0, 0, 0, 0x0, 0xF, 0, 0; irq=0.
2. Falling edge capture: DEBOUNCE=0, IRQ_MASK=0x1, in_port 0xF→0xE → EDGE_CAP=0x1 on edge 3 after the change; irq rises the same edge. Write 0x1 to address 3 → EDGE_CAP=0, irq=0.
3. Glitch rejection: DEBOUNCE=5, in_port[2] low for 5 cycles → DATA unchanged, EDGE_CAP=0. Low for 6 cycles → DATA[2]=0 after 8 edges, EDGE_CAP[2]=1.
4. Both edges on channel 1: RISE_EN=FALL_EN=0x2, toggle in_port[1] 0→1, clear, 1→0 → EDGE_CAP=0x2 after each transition; channels 0, 2, 3 with RISE_EN=0 rising → no capture.
5. Set/clear collision: commit event on channel 3 on the same edge as a W1C write of 0x8 → EDGE_CAP[3]=1 remains; W1C of 0x1 leaves bit 3 set.
6. Debounce change mid-count: DEBOUNCE=100, input held changed for 40 cycles, then write DEBOUNCE=10 → commit on the edge after the write; cnt returns to 0.

Source files
------------

// File: rtl/pio_irq_debounce.sv
// Multi-channel Avalon-MM input PIO with per-channel synchroniser, debounce
// filter and rising/falling edge capture driving a level interrupt.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[2:0]      register word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data (bits above WIDTH / CNT_W ignored)
//   readdata[31:0]    registered read data, 1-cycle latency
//   in_port[WIDTH]    asynchronous external inputs
//   irq               level interrupt, |(EDGE_CAP & IRQ_MASK)
//
// Register map: 0 DATA, 1 RAW, 2 IRQ_MASK, 3 EDGE_CAP (W1C), 4 RISE_EN,
//               5 FALL_EN, 6 DEBOUNCE, 7 reserved (reads 0).
module pio_irq_debounce #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [WIDTH-1:0] RISE_RESET  = '0,
    parameter logic [WIDTH-1:0] FALL_RESET  = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RAW   = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_RISE  = 3'd4;
    localparam logic [2:0] ADDR_FALL  = 3'd5;
    localparam logic [2:0] ADDR_DEBNC = 3'd6;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
    logic [CNT_W-1:0]                  debounce_q, debounce_d;
    logic [31:0]                       readdata_q, readdata_d;

    logic [WIDTH-1:0] sync_c;
    logic [WIDTH-1:0] commit_c;
    logic [WIDTH-1:0] edge_clr_c;
    logic             wr_en_c;

    // Only the low WIDTH / CNT_W bits of writedata carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign sync_c  = sync_q[SYNC_STAGES-1];
    assign wr_en_c = chipselect & ~write_n;

    // Synchroniser shift: stage 0 samples the pins.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    end

    // Debounce: count cycles of disagreement, commit once the count reaches DEBOUNCE.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        commit_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_c[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= debounce_q) begin
                commit_c[i] = 1'b1;
                stable_d[i] = sync_c[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge capture: a set event on the same edge as a W1C clear wins.
    always_comb begin
        edge_clr_c = '0;
        if (wr_en_c && address == ADDR_EDGE) begin
            edge_clr_c = writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~edge_clr_c)
                   | (commit_c &  sync_c & rise_en_q)
                   | (commit_c & ~sync_c & fall_en_q);
    end

    // Control register writes.
    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        debounce_d = debounce_q;
        if (wr_en_c) begin
            case (address)
                ADDR_MASK:  irq_mask_d = writedata[WIDTH-1:0];
                ADDR_RISE:  rise_en_d  = writedata[WIDTH-1:0];
                ADDR_FALL:  fall_en_d  = writedata[WIDTH-1:0];
                ADDR_DEBNC: debounce_d = writedata[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    // Read mux, sampled every edge regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:  readdata_d = 32'(stable_q);
            ADDR_RAW:   readdata_d = 32'(sync_c);
            ADDR_MASK:  readdata_d = 32'(irq_mask_q);
            ADDR_EDGE:  readdata_d = 32'(edge_cap_q);
            ADDR_RISE:  readdata_d = 32'(rise_en_q);
            ADDR_FALL:  readdata_d = 32'(fall_en_q);
            ADDR_DEBNC: readdata_d = 32'(debounce_q);
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            rise_en_q  <= RISE_RESET;
            fall_en_q  <= FALL_RESET;
            debounce_q <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            debounce_q <= debounce_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
